// File: rtl/pipe_stage_chain_if.sv
// Bundle of the entry, control, stage-view and lookup signals of pipe_stage_chain.
// master: the core side driving entries and lookups; slave: the stage chain itself.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [AW-1:0]          in_rd;
  logic                   in_regwr;
  logic                   in_isload;
  logic                   stall;
  logic [DEPTH-1:0]       flush;
  logic [AW-1:0]          rs1_addr;
  logic [AW-1:0]          rs2_addr;
  logic                   in_ready;
  logic [DEPTH-1:0]       stg_valid;
  logic [DEPTH*WIDTH-1:0] stg_data;
  logic [DEPTH*AW-1:0]    stg_rd;
  logic [SELW-1:0]        fwd1_sel;
  logic [SELW-1:0]        fwd2_sel;
  logic [WIDTH-1:0]       fwd1_data;
  logic [WIDTH-1:0]       fwd2_data;
  logic                   hazard;

  modport master (
    output in_valid, in_data, in_rd, in_regwr, in_isload, stall, flush, rs1_addr, rs2_addr,
    input  in_ready, stg_valid, stg_data, stg_rd, fwd1_sel, fwd2_sel, fwd1_data, fwd2_data,
           hazard
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_regwr, in_isload, stall, flush, rs1_addr, rs2_addr,
    output in_ready, stg_valid, stg_data, stg_rd, fwd1_sel, fwd2_sel, fwd1_data, fwd2_data,
           hazard
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline registers (stage 0 youngest, DEPTH-1 oldest) with
// stall/flush control and the rs1/rs2 forwarding and load-use hazard lookup.
// Build option PIPE_FWD_EN: when defined, forwarding muxes are present and only a load in
// stage 0 raises hazard; when undefined, forwarding outputs are 0 and any in-flight writer
// of a source register raises hazard until it drains.
// State updates on the falling clock edge; clr is a synchronous active-low reset.
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5
) (
  input logic               clk,
  input logic               clr,
  pipe_stage_chain_if.slave bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            regwr_q, regwr_d;
  logic [DEPTH-1:0]            isload_q, isload_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0][AW-1:0]    rd_q, rd_d;

  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] match1, match2;
  logic [SELW-1:0]  fwd1_sel, fwd2_sel;
  logic [WIDTH-1:0] fwd1_data, fwd2_data;
  logic             hazard;

  // Only the stage-0 load flag feeds the hazard; the rest just travels with the entry.
  logic unused_isload;
  assign unused_isload = ^isload_q;

  // Next-state: shift, stall (hold stage 0, bubble into stage 1), then flush masks valid.
  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    isload_d = isload_q;
    data_d   = data_q;
    rd_d     = rd_q;

    if (!bus.stall) begin
      valid_d[0]  = bus.in_valid;
      regwr_d[0]  = bus.in_regwr;
      isload_d[0] = bus.in_isload;
      data_d[0]   = bus.in_data;
      rd_d[0]     = bus.in_rd;
    end

    if (bus.stall) begin
      valid_d[1]  = 1'b0;
      regwr_d[1]  = 1'b0;
      isload_d[1] = 1'b0;
      data_d[1]   = '0;
      rd_d[1]     = '0;
    end else begin
      valid_d[1]  = valid_q[0];
      regwr_d[1]  = regwr_q[0];
      isload_d[1] = isload_q[0];
      data_d[1]   = data_q[0];
      rd_d[1]     = rd_q[0];
    end

    for (int unsigned i = 2; i < DEPTH; i++) begin
      valid_d[i]  = valid_q[i-1];
      regwr_d[i]  = regwr_q[i-1];
      isload_d[i] = isload_q[i-1];
      data_d[i]   = data_q[i-1];
      rd_d[i]     = rd_q[i-1];
    end

    // Flush clears valid only; payload is still loaded (and held under stall).
    valid_d = valid_d & ~bus.flush;
  end

  // Stage registers, falling-edge, synchronous active-low clear overriding stall/flush.
  always_ff @(negedge clk) begin
    if (!clr) begin
      valid_q  <= '0;
      regwr_q  <= '0;
      isload_q <= '0;
      data_q   <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      isload_q <= isload_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
    end
  end

  assign stg_valid = valid_q & regwr_q;

  // Per-stage source match; register 0 never matches.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match1[i] = stg_valid[i] && (rd_q[i] == bus.rs1_addr) && (bus.rs1_addr != '0);
      match2[i] = stg_valid[i] && (rd_q[i] == bus.rs2_addr) && (bus.rs2_addr != '0);
    end
  end

`ifdef PIPE_FWD_EN
  // Priority select: scan oldest to youngest so the youngest match is written last.
  always_comb begin
    fwd1_sel  = '0;
    fwd2_sel  = '0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) begin
        fwd1_sel  = SELW'(i + 1);
        fwd1_data = data_q[i];
      end
      if (match2[i]) begin
        fwd2_sel  = SELW'(i + 1);
        fwd2_data = data_q[i];
      end
    end
  end

  // Load-use: a load's data is not available until it reaches stage 1.
  assign hazard = (match1[0] | match2[0]) & isload_q[0];
`else
  assign fwd1_sel  = '0;
  assign fwd2_sel  = '0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;

  // Without forwarding, ID waits for any in-flight writer of a source to drain.
  assign hazard = |(match1 | match2);
`endif

  assign bus.in_ready  = ~bus.stall;
  assign bus.stg_valid = stg_valid;
  assign bus.stg_data  = data_q;
  assign bus.stg_rd    = rd_q;
  assign bus.fwd1_sel  = fwd1_sel;
  assign bus.fwd2_sel  = fwd2_sel;
  assign bus.fwd1_data = fwd1_data;
  assign bus.fwd2_data = fwd2_data;
  assign bus.hazard    = hazard;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=3); expectations follow the PIPE_FWD_EN build option.
module tb_pipe_stage_chain;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned AW    = 5;
`ifdef PIPE_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one state-update edge and let outputs settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic regwr, input logic isload);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_rd     = rd;
    bus.in_regwr  = regwr;
    bus.in_isload = isload;
  endtask

  function automatic logic [95:0] d3(input logic [31:0] s2, input logic [31:0] s1,
                                     input logic [31:0] s0);
    return {s2, s1, s0};
  endfunction

  function automatic logic [14:0] r3(input logic [4:0] s2, input logic [4:0] s1,
                                     input logic [4:0] s0);
    return {s2, s1, s0};
  endfunction

  initial begin
    bus.stall    = 1'b0;
    bus.flush    = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    drive(1'b1, 32'h55, 5'd1, 1'b1, 1'b0);

    // 1. reset with in_valid asserted
    clr = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 128'(bus.stg_valid), 128'(3'b000));
    chk("rst_data", 128'(bus.stg_data), 128'(96'h0));
    chk("rst_rd", 128'(bus.stg_rd), 128'(15'h0));
    chk("rst_hazard", 128'(bus.hazard), 128'(1'b0));
    chk("rst_ready", 128'(bus.in_ready), 128'(1'b1));
    clr = 1'b1;

    // 2. single entry walks the chain with rs1 watching it
    drive(1'b1, 32'h11, 5'd5, 1'b1, 1'b0);
    bus.rs1_addr = 5'd5;
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("walk0_valid", 128'(bus.stg_valid), 128'(3'b001));
    chk("walk0_sel", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd1 : 2'd0));
    chk("walk0_data", 128'(bus.fwd1_data), 128'(Fwd ? 32'h11 : 32'h0));
    chk("walk0_hazard", 128'(bus.hazard), 128'(!Fwd));
    tick();
    chk("walk1_valid", 128'(bus.stg_valid), 128'(3'b010));
    chk("walk1_sel", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd2 : 2'd0));
    chk("walk1_data", 128'(bus.fwd1_data), 128'(Fwd ? 32'h11 : 32'h0));
    chk("walk1_hazard", 128'(bus.hazard), 128'(!Fwd));
    tick();
    chk("walk2_valid", 128'(bus.stg_valid), 128'(3'b100));
    chk("walk2_stgdata", 128'(bus.stg_data), 128'(d3(32'h11, 32'h0, 32'h0)));
    chk("walk2_sel", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd3 : 2'd0));
    chk("walk2_data", 128'(bus.fwd1_data), 128'(Fwd ? 32'h11 : 32'h0));
    chk("walk2_hazard", 128'(bus.hazard), 128'(!Fwd));
    tick();
    chk("walk3_valid", 128'(bus.stg_valid), 128'(3'b000));
    chk("walk3_sel", 128'(bus.fwd1_sel), 128'(2'd0));
    chk("walk3_hazard", 128'(bus.hazard), 128'(1'b0));

    // 3. youngest match wins: s0=rd7/0xA, s1=rd9/0xC, s2=rd7/0xB
    drive(1'b1, 32'hB, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hC, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hA, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd7;
    #1;
    chk("young_rd", 128'(bus.stg_rd), 128'(r3(5'd7, 5'd9, 5'd7)));
    chk("young_sel2", 128'(bus.fwd2_sel), 128'(Fwd ? 2'd1 : 2'd0));
    chk("young_data2", 128'(bus.fwd2_data), 128'(Fwd ? 32'hA : 32'h0));
    chk("young_sel1", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd2 : 2'd0));
    chk("young_data1", 128'(bus.fwd1_data), 128'(Fwd ? 32'hC : 32'h0));
    chk("young_hazard", 128'(bus.hazard), 128'(!Fwd));
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd4;
    #1;
    chk("nomatch_hazard", 128'(bus.hazard), 128'(1'b0));
    chk("nomatch_sel2", 128'(bus.fwd2_sel), 128'(2'd0));

    // 4. load-use hazard, then one stall edge
    drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b1);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd0;
    tick();
    chk("load_hazard", 128'(bus.hazard), 128'(1'b1));
    chk("load_sel1", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd1 : 2'd0));
    chk("load_data1", 128'(bus.fwd1_data), 128'(Fwd ? 32'h33 : 32'h0));
    bus.stall = 1'b1;
    drive(1'b1, 32'h44, 5'd4, 1'b1, 1'b0);
    #1;
    chk("stall_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    chk("stall_valid", 128'(bus.stg_valid), 128'(3'b101));
    chk("stall_data", 128'(bus.stg_data), 128'(d3(32'hA, 32'h0, 32'h33)));
    chk("stall_rd", 128'(bus.stg_rd), 128'(r3(5'd7, 5'd0, 5'd3)));
    chk("stall_hazard", 128'(bus.hazard), 128'(1'b1));
    bus.stall = 1'b0;
    tick();
    chk("resume_valid", 128'(bus.stg_valid), 128'(3'b011));
    chk("resume_data", 128'(bus.stg_data), 128'(d3(32'h0, 32'h33, 32'h44)));
    chk("resume_hazard", 128'(bus.hazard), 128'(!Fwd));
    chk("resume_sel1", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd2 : 2'd0));
    chk("resume_data1", 128'(bus.fwd1_data), 128'(Fwd ? 32'h33 : 32'h0));

    // 5. flush stages 0 and 1; stage 2 takes the old stage 1 entry
    drive(1'b1, 32'h55, 5'd5, 1'b1, 1'b0);
    bus.flush = 3'b011;
    tick();
    bus.flush = 3'b000;
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd5;
    #1;
    chk("flush_valid", 128'(bus.stg_valid), 128'(3'b100));
    chk("flush_data", 128'(bus.stg_data), 128'(d3(32'h33, 32'h44, 32'h55)));
    chk("flush_sel1", 128'(bus.fwd1_sel), 128'(Fwd ? 2'd3 : 2'd0));
    chk("flush_data1", 128'(bus.fwd1_data), 128'(Fwd ? 32'h33 : 32'h0));
    chk("flush_sel2", 128'(bus.fwd2_sel), 128'(2'd0));
    chk("flush_hazard", 128'(bus.hazard), 128'(!Fwd));
    // flush[0] with stall: stage 0 invalidated, payload held
    drive(1'b1, 32'h66, 5'd6, 1'b1, 1'b0);
    tick();
    chk("push66_valid", 128'(bus.stg_valid), 128'(3'b001));
    bus.stall = 1'b1;
    bus.flush = 3'b001;
    drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b0);
    tick();
    bus.stall = 1'b0;
    bus.flush = 3'b000;
    bus.rs1_addr = 5'd6;
    bus.rs2_addr = 5'd0;
    #1;
    chk("fstall_valid", 128'(bus.stg_valid), 128'(3'b000));
    chk("fstall_data", 128'(bus.stg_data), 128'(d3(32'h55, 32'h0, 32'h66)));
    chk("fstall_hazard", 128'(bus.hazard), 128'(1'b0));
    chk("fstall_sel1", 128'(bus.fwd1_sel), 128'(2'd0));

    // 6. register 0 never matches; regwr=0 entries are not visible
    drive(1'b1, 32'h99, 5'd0, 1'b1, 1'b0);
    bus.rs1_addr = 5'd0;
    tick();
    chk("r0_valid", 128'(bus.stg_valid), 128'(3'b001));
    chk("r0_sel1", 128'(bus.fwd1_sel), 128'(2'd0));
    chk("r0_hazard", 128'(bus.hazard), 128'(1'b0));
    drive(1'b1, 32'h88, 5'd8, 1'b0, 1'b0);
    bus.rs1_addr = 5'd8;
    tick();
    chk("nowr_valid", 128'(bus.stg_valid), 128'(3'b010));
    chk("nowr_hazard", 128'(bus.hazard), 128'(1'b0));
    chk("nowr_sel1", 128'(bus.fwd1_sel), 128'(2'd0));

    // reset overrides stall and flush mid-run
    clr = 1'b0;
    bus.stall = 1'b1;
    bus.flush = 3'b111;
    tick();
    chk("rst2_valid", 128'(bus.stg_valid), 128'(3'b000));
    chk("rst2_data", 128'(bus.stg_data), 128'(96'h0));
    chk("rst2_rd", 128'(bus.stg_rd), 128'(15'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
